// File: rtl/turbo_encoder_if.sv
// Block handshake and bit-plane output bus between the turbo encoder and its consumer.
// master drives info bits; slave is the encoder.
interface turbo_encoder_if;
   localparam int unsigned INFO_W  = 5;
   localparam int unsigned PLANE_W = 21;

   logic [INFO_W-1:0]  data_i;
   logic               valid_i;
   logic               ready_o;
   logic [PLANE_W-1:0] data_o;
   logic               start_o;
   logic               done_o;

   modport master (output data_i, valid_i, input ready_o, data_o, start_o, done_o);
   modport slave  (input data_i, valid_i, output ready_o, data_o, start_o, done_o);
endinterface

// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two RSC(1+D+D^2, 1+D^2) encoders around a 7-point interleaver,
// streamed as four soft-value bit-plane words {sys, par1, par2}.
module turbo_encoder #(
   parameter int unsigned INPUT_SIZE  = 5,
   parameter int unsigned EXTEND_SIZE = 7,
   parameter int unsigned SOFT_W      = 4
) (
   input  logic            clk_p_i,
   input  logic            reset_n_i,
   turbo_encoder_if.slave  bus
);
   localparam int unsigned POS_W   = $clog2(EXTEND_SIZE);
   localparam int unsigned PLANE_W = 3 * EXTEND_SIZE;
   localparam int unsigned PCNT_W  = $clog2(SOFT_W);

   typedef enum logic [1:0] {S_IDLE, S_ENC1, S_ENC2, S_SEND} state_t;

   typedef struct packed {
      logic [EXTEND_SIZE-1:0] sys;
      logic [EXTEND_SIZE-1:0] par1;
      logic [EXTEND_SIZE-1:0] par2;
   } plane_t;

   state_t                  state;
   logic [INPUT_SIZE-1:0]   info;
   logic [POS_W-1:0]        pos;
   logic [PCNT_W-1:0]       plane_cnt;
   logic [EXTEND_SIZE-1:0]  sys, par1, par2;
   logic                    enc1_s1, enc1_s2, enc2_s1, enc2_s2;

   logic [EXTEND_SIZE-1:0]  info_ext, sys2;
   logic                    enc1_u, enc1_a, enc1_p;
   logic                    enc2_u, enc2_a, enc2_p;
   plane_t                  word;
   logic [PLANE_W-1:0]      plane_next;
   logic [PCNT_W-1:0]       plane_cnt_nxt;

   assign bus.ready_o = (state == S_IDLE);

   // Per-position encoder datapath; tail positions 1..0 drive encoder 1 back to (0,0).
   always_comb begin
      info_ext      = {info, 2'b00};
      enc1_u        = (pos >= POS_W'(2)) ? info_ext[pos] : (enc1_s1 ^ enc1_s2);
      enc1_a        = enc1_u ^ enc1_s1 ^ enc1_s2;
      enc1_p        = enc1_a ^ enc1_s2;
      sys2          = {sys[0], sys[4], sys[1], sys[5], sys[2], sys[6], sys[3]};
      enc2_u        = sys2[pos];
      enc2_a        = enc2_u ^ enc2_s1 ^ enc2_s2;
      enc2_p        = enc2_a ^ enc2_s2;
      word          = '{sys: sys, par1: par1, par2: par2};
      plane_cnt_nxt = plane_cnt + PCNT_W'(1);
      // +7 = 4'b0111, -7 = 4'b1001: plane0 constant, planes 1/2 the bit, plane3 its inverse
      case (plane_cnt_nxt)
         PCNT_W'(0): plane_next = '1;
         PCNT_W'(3): plane_next = ~word;
         default:    plane_next = word;
      endcase
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state       <= S_IDLE;
         info        <= '0;
         pos         <= '0;
         plane_cnt   <= '0;
         sys         <= '0;
         par1        <= '0;
         par2        <= '0;
         enc1_s1     <= 1'b0;
         enc1_s2     <= 1'b0;
         enc2_s1     <= 1'b0;
         enc2_s2     <= 1'b0;
         bus.data_o  <= '0;
         bus.start_o <= 1'b0;
         bus.done_o  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.valid_i) begin
                  info    <= bus.data_i;
                  pos     <= POS_W'(EXTEND_SIZE - 1);
                  enc1_s1 <= 1'b0;
                  enc1_s2 <= 1'b0;
                  enc2_s1 <= 1'b0;
                  enc2_s2 <= 1'b0;
                  state   <= S_ENC1;
               end
            end
            S_ENC1: begin
               sys[pos]  <= enc1_u;
               par1[pos] <= enc1_p;
               enc1_s1   <= enc1_a;
               enc1_s2   <= enc1_s1;
               if (pos == '0) begin
                  pos   <= POS_W'(EXTEND_SIZE - 1);
                  state <= S_ENC2;
               end else begin
                  pos <= pos - POS_W'(1);
               end
            end
            S_ENC2: begin
               par2[pos] <= enc2_p;
               enc2_s1   <= enc2_a;
               enc2_s2   <= enc2_s1;
               if (pos == '0) begin
                  plane_cnt   <= '0;
                  bus.data_o  <= '1;
                  bus.start_o <= 1'b1;
                  state       <= S_SEND;
               end else begin
                  pos <= pos - POS_W'(1);
               end
            end
            S_SEND: begin
               if (plane_cnt == PCNT_W'(SOFT_W - 1)) begin
                  bus.data_o  <= '0;
                  bus.start_o <= 1'b0;
                  bus.done_o  <= 1'b0;
                  state       <= S_IDLE;
               end else begin
                  plane_cnt  <= plane_cnt_nxt;
                  bus.data_o <= plane_next;
                  bus.done_o <= (plane_cnt_nxt == PCNT_W'(SOFT_W - 1));
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_turbo_encoder.sv
// Directed and random block checks for turbo_encoder: handshake timing, planes, reset abort.
module tb_turbo_encoder;
   logic clk_p_i = 1'b0;
   logic reset_n_i;
   int   errors = 0;
   int   checks = 0;

   turbo_encoder_if bus ();

   turbo_encoder dut (
      .clk_p_i   (clk_p_i),
      .reset_n_i (reset_n_i),
      .bus       (bus)
   );

   always #5 clk_p_i = ~clk_p_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: loop-based RSC pair with interleaver table, returns {sys, par1, par2}.
   function automatic logic [20:0] ref_word(input logic [4:0] d);
      logic [6:0] s, p1, p2, s2v;
      logic       r1, r2, u, a;
      int         perm [7] = '{3, 6, 2, 5, 1, 4, 0};
      r1 = 0; r2 = 0;
      for (int n = 6; n >= 0; n--) begin
         u     = (n >= 2) ? d[n-2] : (r1 ^ r2);
         a     = u ^ r1 ^ r2;
         s[n]  = u;
         p1[n] = a ^ r2;
         r2    = r1;
         r1    = a;
      end
      for (int k = 0; k < 7; k++) s2v[k] = s[perm[k]];
      r1 = 0; r2 = 0;
      for (int n = 6; n >= 0; n--) begin
         a     = s2v[n] ^ r1 ^ r2;
         p2[n] = a ^ r2;
         r2    = r1;
         r1    = a;
      end
      return {s, p1, p2};
   endfunction

   // Handshake in the current idle cycle, then check cycles 1..18 of the block.
   task automatic run_block(input logic [4:0] d, input logic [20:0] w, input bit hold);
      logic [20:0] exp_plane;
      @(negedge clk_p_i);
      check("ready_idle", 32'(bus.ready_o), 32'd1);
      check("enc1_end_state", 32'({dut.enc1_s1, dut.enc1_s2}), 32'd0);
      bus.data_i  = d;
      bus.valid_i = 1'b1;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         @(negedge clk_p_i);
         bus.data_i  = ~d;
         bus.valid_i = hold ? 1'b1 : ((cyc == 3 || cyc == 10) ? 1'b1 : 1'b0);
         case (cyc)
            15:      exp_plane = 21'h1FFFFF;
            16, 17:  exp_plane = w;
            18:      exp_plane = ~w;
            default: exp_plane = 21'h0;
         endcase
         check("ready_busy", 32'(bus.ready_o), 32'd0);
         check("start", 32'(bus.start_o), 32'((cyc >= 15) ? 1 : 0));
         check("done", 32'(bus.done_o), 32'((cyc == 18) ? 1 : 0));
         check("plane", 32'(bus.data_o), 32'(exp_plane));
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
      check({tag, "_start"}, 32'(bus.start_o), 32'd0);
      check({tag, "_done"},  32'(bus.done_o),  32'd0);
      check({tag, "_data"},  32'(bus.data_o),  32'd0);
   endtask

   // Accept a block, then pulse reset at the given cycle of that block.
   task automatic abort_block(input logic [4:0] d, input int at_cyc, input logic exp_start);
      @(negedge clk_p_i);
      bus.data_i  = d;
      bus.valid_i = 1'b1;
      repeat (at_cyc) @(negedge clk_p_i);
      bus.valid_i = 1'b0;
      check("pre_abort_start", 32'(bus.start_o), 32'(exp_start));
      reset_n_i = 1'b0;
      #1;
      check_reset_values("abort");
      @(negedge clk_p_i);
      check_reset_values("abort_hold");
      reset_n_i = 1'b1;
   endtask

   initial begin
      logic [4:0] d;
      reset_n_i   = 1'b0;
      bus.data_i  = '0;
      bus.valid_i = 1'b0;
      repeat (3) @(negedge clk_p_i);
      check_reset_values("reset");
      reset_n_i = 1'b1;

      run_block(5'b00000, 21'h000000, 1'b0);
      run_block(5'b10000, 21'h107BF5, 1'b0);

      for (int i = 0; i < 4; i++) begin
         d = 5'($urandom);
         run_block(d, ref_word(d), 1'b1);
      end

      abort_block(5'b10110, 10, 1'b0);
      run_block(5'b00000, 21'h000000, 1'b0);
      abort_block(5'b11111, 16, 1'b1);
      run_block(5'b00000, 21'h000000, 1'b0);

      for (int i = 0; i < 1000; i++) begin
         d = 5'($urandom);
         run_block(d, ref_word(d), bit'($urandom_range(0, 1)));
      end

      @(negedge clk_p_i);
      bus.valid_i = 1'b0;
      check("final_ready", 32'(bus.ready_o), 32'd1);
      check("final_enc1_state", 32'({dut.enc1_s1, dut.enc1_s2}), 32'd0);
      @(negedge clk_p_i);
      check_reset_values("final_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
